// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst-length decoding for the bus arbiter.
package ahb_pkg;

  localparam int MAX_MASTERS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEC = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Fixed burst length in beats; 0 marks undefined-length INCR.
  function automatic logic [4:0] burst_len(input hburst_e b);
    logic [4:0] len;
    case (b)
      SINGLE:          len = 5'd1;
      WRAP4, INCR4:    len = 5'd4;
      WRAP8, INCR8:    len = 5'd8;
      WRAP16, INCR16:  len = 5'd16;
      default:         len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration-side AHB signals: master requests in, grant/ownership out.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [3:0]             hmaster;
  logic [3:0]             hmaster_d;
  logic                   hmastlock;

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready,
    output hgrant, hmaster, hmaster_d, hmastlock
  );

  modport master (
    output hbusreq, hlock, htrans, hburst, hready,
    input  hgrant, hmaster, hmaster_d, hmastlock
  );
endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: scans from last_i+1 upward with wrap,
// so the previous owner has lowest priority.
module ahb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [3:0]   last_i,
  output logic [N-1:0] grant_o,
  output logic [3:0]   idx_o,
  output logic         any_req_o
);

  logic [4:0]   shamt;
  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;
  logic [3:0]   masked [N];

  // Rotate so bit k of rot corresponds to master (last_i + 1 + k) mod N.
  assign shamt     = {1'b0, last_i} + 5'd1;
  assign rot       = N'({req_i, req_i} >> shamt);
  assign rot_oh    = rot & (~rot + N'(1));
  assign any_req_o = |req_i;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pos
      logic [4:0] sum;
      logic [3:0] pos;
      assign sum         = shamt + 5'(gi);
      assign pos         = (sum >= 5'(N)) ? 4'(sum - 5'(N)) : 4'(sum);
      assign masked[gi]  = rot_oh[gi] ? pos : 4'd0;
      assign grant_o[gi] = any_req_o && (idx_o == 4'(gi));
    end
  endgenerate

  always_comb begin
    idx_o = 4'd0;
    for (int i = 0; i < N; i++) begin
      idx_o = idx_o | masked[i];
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter honouring fixed bursts and locked sequences;
// all outputs are registered and frozen while hready is low.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input logic              hclk,
  input logic              hreset,
  ahb_bus_arbiter_if.slave bus
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);

  arb_state_e             state_q, state_d;
  logic [4:0]             beats_q, beats_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [3:0]             hmaster_q, hmaster_d;
  logic [3:0]             hmaster_dp_q, hmaster_dp_d;
  logic                   hmastlock_q, hmastlock_d;

  htrans_e                trans;
  hburst_e                burst;
  logic [4:0]             len;
  logic [4:0]             beats_upd;
  logic                   fixed_burst;
  logic                   owner_lock;
  logic                   seq_or_busy;
  logic                   handover_pt;
  logic                   lock_hold;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [3:0]             pick_idx;
  logic                   pick_any;

  assign trans       = htrans_e'(bus.htrans);
  assign burst       = hburst_e'(bus.hburst);
  assign len         = burst_len(burst);
  assign fixed_burst = (len != 5'd0);
  // hgrant is one-hot, so this selects hlock of the current owner.
  assign owner_lock  = |(bus.hlock & hgrant_q);
  assign seq_or_busy = (trans == SEQ) || (trans == BUSY);

  ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i     (bus.hbusreq),
    .last_i    (hmaster_q),
    .grant_o   (pick_grant),
    .idx_o     (pick_idx),
    .any_req_o (pick_any)
  );

  always_comb begin
    beats_upd = beats_q;
    case (trans)
      NONSEC:  beats_upd = fixed_burst ? len - 5'd1 : 5'd0;
      SEQ:     beats_upd = (beats_q == 5'd0) ? 5'd0 : beats_q - 5'd1;
      IDLE:    beats_upd = 5'd0;
      default: beats_upd = beats_q;
    endcase
  end

  assign handover_pt = (trans == IDLE)
                    || (((trans == NONSEC) || (trans == SEQ)) && fixed_burst && (beats_upd == 5'd0))
                    || ((burst == INCR) && (trans != BUSY));
  // A just-unlocked owner still finishing SEQ/BUSY beats keeps the bus.
  assign lock_hold = owner_lock || ((state_q == ST_LOCKED) && seq_or_busy);

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    hgrant_d     = hgrant_q;
    hmaster_d    = hmaster_q;
    hmaster_dp_d = hmaster_dp_q;
    hmastlock_d  = hmastlock_q;
    if (bus.hready) begin
      beats_d      = beats_upd;
      hmaster_dp_d = hmaster_q;
      hmastlock_d  = owner_lock;
      if (lock_hold) begin
        state_d = ST_LOCKED;
      end else begin
        state_d = (beats_upd != 5'd0) ? ST_BURST : ST_ARB;
      end
      if (handover_pt && !lock_hold) begin
        if (pick_any) begin
          hgrant_d  = pick_grant;
          hmaster_d = pick_idx;
        end else begin
          hgrant_d  = DEF_GRANT;
          hmaster_d = DEF_IDX;
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ST_ARB;
      beats_q      <= 5'd0;
      hgrant_q     <= DEF_GRANT;
      hmaster_q    <= DEF_IDX;
      hmaster_dp_q <= DEF_IDX;
      hmastlock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hmaster_dp_q <= hmaster_dp_d;
      hmastlock_q  <= hmastlock_d;
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmaster_d = hmaster_dp_q;
  assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench: driver queues hand-computed post-edge ownership, monitor
// pops one entry after every rising edge and compares.
module tb_ahb_bus_arbiter;

  logic clk;
  logic hreset;

  ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk   (clk),
    .hreset (hreset),
    .bus    (bus)
  );

  typedef struct {
    string      nm;
    logic [3:0] m;
    logic [3:0] md;
    logic       ml;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input string nm, input logic rst, input logic [3:0] req,
                     input logic [3:0] lck, input logic [1:0] tr, input logic [2:0] bu,
                     input logic rdy, input logic [3:0] em, input logic [3:0] emd,
                     input logic eml);
    exp_t e;
    @(negedge clk);
    hreset      = rst;
    bus.hbusreq = req;
    bus.hlock   = lck;
    bus.htrans  = tr;
    bus.hburst  = bu;
    bus.hready  = rdy;
    e.nm = nm; e.m = em; e.md = emd; e.ml = eml;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [3:0] eg;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        eg = 4'b0001 << e.m;
        n_cmp++;
        if (bus.hgrant !== eg || bus.hmaster !== e.m ||
            bus.hmaster_d !== e.md || bus.hmastlock !== e.ml) begin
          n_bad++;
          $display("FAIL %s: got hgrant=%b hmaster=%0d hmaster_d=%0d hmastlock=%b, want hgrant=%b hmaster=%0d hmaster_d=%0d hmastlock=%b",
                   e.nm, bus.hgrant, bus.hmaster, bus.hmaster_d, bus.hmastlock,
                   eg, e.m, e.md, e.ml);
        end else begin
          $display("ok   %s: hmaster=%0d hmaster_d=%0d hmastlock=%b", e.nm,
                   bus.hmaster, bus.hmaster_d, bus.hmastlock);
        end
      end
    end
  end

  // Driver: htrans IDLE=0 BUSY=1 NONSEC=2 SEQ=3; hburst SINGLE=0 INCR=1 INCR4=3 INCR8=5
  initial begin
    hreset = 1'b1;
    bus.hbusreq = 4'b0000; bus.hlock = 4'b0000;
    bus.htrans = 2'd0; bus.hburst = 3'd0; bus.hready = 1'b1;

    cyc("reset",        1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("park_idle",  0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 0, 0, 0);

    cyc("rr_to_1",      0, 4'b0110, 4'b0000, 2'd0, 3'd0, 1, 1, 0, 0);
    cyc("rr_to_2",      0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2, 1, 0);
    cyc("park_again",   0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 0, 2, 0);
    cyc("grant_1",      0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1, 1, 0, 0);

    cyc("incr4_nonsec", 0, 4'b1010, 4'b0000, 2'd2, 3'd3, 1, 1, 1, 0);
    cyc("incr4_wait",   0, 4'b1010, 4'b0000, 2'd3, 3'd3, 0, 1, 1, 0);
    cyc("incr4_seq2",   0, 4'b1010, 4'b0000, 2'd3, 3'd3, 1, 1, 1, 0);
    cyc("incr4_busy",   0, 4'b1010, 4'b0000, 2'd1, 3'd3, 1, 1, 1, 0);
    cyc("incr4_seq3",   0, 4'b1010, 4'b0000, 2'd3, 3'd3, 1, 1, 1, 0);
    cyc("incr4_last",   0, 4'b1010, 4'b0000, 2'd3, 3'd3, 1, 3, 1, 0);

    cyc("grant_2",      0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2, 3, 0);
    for (int i = 0; i < 3; i++)
      cyc("lock_single",0, 4'b1101, 4'b0100, 2'd2, 3'd0, 1, 2, 2, 1);
    cyc("lock_drop",    0, 4'b1101, 4'b0000, 2'd0, 3'd0, 1, 3, 2, 0);

    cyc("incr8_b1",     0, 4'b1000, 4'b0000, 2'd2, 3'd5, 1, 3, 3, 0);
    for (int i = 0; i < 3; i++)
      cyc("incr8_seq",  0, 4'b1000, 4'b0000, 2'd3, 3'd5, 1, 3, 3, 0);
    cyc("incr8_reset",  1, 4'b1110, 4'b0000, 2'd3, 3'd5, 1, 0, 0, 0);
    cyc("post_rst_seq", 0, 4'b1000, 4'b0000, 2'd3, 3'd5, 1, 3, 0, 0);

    for (int i = 0; i < 10; i++)
      cyc("ready_low",  0, 4'b0111, 4'b1000, 2'd0, 3'd0, 0, 3, 0, 0);
    cyc("ready_back",   0, 4'b0111, 4'b0000, 2'd0, 3'd0, 1, 0, 3, 0);

    cyc("owner_only",   0, 4'b0001, 4'b0000, 2'd0, 3'd0, 1, 0, 0, 0);
    cyc("scan_to_3",    0, 4'b1001, 4'b0000, 2'd0, 3'd0, 1, 3, 0, 0);
    cyc("wrap_to_0",    0, 4'b1001, 4'b0000, 2'd0, 3'd0, 1, 0, 3, 0);

    cyc("incr_nonsec",  0, 4'b0011, 4'b0000, 2'd2, 3'd1, 1, 1, 0, 0);
    cyc("incr_busy",    0, 4'b0011, 4'b0000, 2'd1, 3'd1, 1, 1, 1, 0);
    cyc("incr_seq",     0, 4'b0011, 4'b0000, 2'd3, 3'd1, 1, 0, 1, 0);
    cyc("single_hand",  0, 4'b0100, 4'b0000, 2'd2, 3'd0, 1, 2, 0, 0);
    cyc("final_park",   0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 0, 2, 0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
